// File: rtl/sa_ws_pkg.sv
// Shared types and defaults for the weight-stationary systolic array drain path.
package sa_ws_pkg;

   localparam int DEF_SA_COL     = 3;
   localparam int DEF_PSUM_WIDTH = 19;

   // One output vector of the array, column 0 in the low lane.
   typedef logic [DEF_SA_COL-1:0][DEF_PSUM_WIDTH-1:0] psum_vec_t;

   // One buffered entry: aligned vector plus its end-of-frame marker.
   typedef struct packed {
      psum_vec_t data;
      logic      last;
   } psum_entry_t;

   // Counter width helper that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sa_psum_fifo.sv
// Small show-ahead FIFO for aligned psum vectors; reports drops instead of stalling.
module sa_psum_fifo
   import sa_ws_pkg::*;
#(
   parameter type T     = psum_entry_t,
   parameter int  DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     i_clr,
   input  logic                     i_push,
   input  T                         i_data,
   input  logic                     i_pop,
   output T                         o_head,
   output logic                     o_valid,
   output logic                     o_drop,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   T              r_mem [DEPTH];

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
   assign w_pop   = i_pop & ~w_empty;
   assign w_push  = i_push & (~w_full | w_pop);
   assign o_drop  = i_push & w_full & ~w_pop;

   // Pointer and occupancy state; clear wins over any push or pop.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // Storage array; contents need no reset because the count masks stale entries.
   always_ff @(posedge clk) begin
      if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_valid = ~w_empty;
   assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/sa_ws_psum_collector.sv
// De-skews bottom-row psums of the systolic array, buffers aligned vectors, tags frame ends.
module sa_ws_psum_collector
   import sa_ws_pkg::*;
#(
   parameter int SA_COL        = DEF_SA_COL,
   parameter int PSUM_WIDTH    = DEF_PSUM_WIDTH,
   parameter int VECTOR_LENGTH = 8,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                                  clk,
   input  logic                                  nrst,
   input  logic                                  clr_i,
   input  logic                                  psum_valid_i,
   input  logic [SA_COL-1:0][PSUM_WIDTH-1:0]     psum_i,
   output logic                                  out_valid_o,
   input  logic                                  out_ready_i,
   output logic [SA_COL-1:0][PSUM_WIDTH-1:0]     out_data_o,
   output logic                                  out_last_o,
   output logic                                  overflow_o,
   output logic [$clog2(FIFO_DEPTH):0]           fifo_count_o
);

   localparam int FC_W = clog2_min1(VECTOR_LENGTH);

   typedef logic [SA_COL-1:0][PSUM_WIDTH-1:0] vec_t;
   typedef struct packed {
      vec_t data;
      logic last;
   } entry_t;

   vec_t            w_aligned;
   logic            w_wr_en;
   logic            w_last;
   logic            w_drop;
   entry_t          w_wr_entry;
   entry_t          w_head;
   logic [FC_W-1:0] r_frame_cnt;
   logic            r_overflow;

   // Column c lags column 0 by c cycles, so it is delayed by SA_COL-1-c stages.
   genvar gi;
   generate
      for (gi = 0; gi < SA_COL; gi++) begin : g_col
         localparam int DLY = SA_COL - 1 - gi;
         if (DLY == 0) begin : g_live
            assign w_aligned[gi] = psum_i[gi];
         end else begin : g_dly
            logic [DLY-1:0][PSUM_WIDTH-1:0] r_dly;
            // Free-running shift; only the valid pipe decides what gets written.
            always_ff @(posedge clk or negedge nrst) begin
               if (!nrst) begin
                  r_dly <= '0;
               end else if (clr_i) begin
                  r_dly <= '0;
               end else begin
                  r_dly[0] <= psum_i[gi];
                  for (int i = 1; i < DLY; i++) r_dly[i] <= r_dly[i-1];
               end
            end
            assign w_aligned[gi] = r_dly[DLY-1];
         end
      end

      if (SA_COL > 1) begin : g_vpipe
         logic [SA_COL-2:0] r_vld;
         // Valid travels with column 0, arriving when the last column is live.
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               r_vld <= '0;
            end else if (clr_i) begin
               r_vld <= '0;
            end else begin
               r_vld[0] <= psum_valid_i;
               for (int i = 1; i < SA_COL - 1; i++) r_vld[i] <= r_vld[i-1];
            end
         end
         assign w_wr_en = r_vld[SA_COL-2];
      end else begin : g_vlive
         assign w_wr_en = psum_valid_i;
      end
   endgenerate

   assign w_last = (r_frame_cnt == FC_W'(VECTOR_LENGTH - 1));

   // Frame position advances on every aligned vector, dropped or not, to stay locked to the array.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_frame_cnt <= '0;
      end else if (clr_i) begin
         r_frame_cnt <= '0;
      end else if (w_wr_en) begin
         r_frame_cnt <= w_last ? '0 : r_frame_cnt + FC_W'(1);
      end
   end

   // Sticky drop flag so downstream can discard the damaged frame.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_overflow <= 1'b0;
      end else if (clr_i) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

   assign w_wr_entry.data = w_aligned;
   assign w_wr_entry.last = w_last;

   sa_psum_fifo #(
      .T     (entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .nrst    (nrst),
      .i_clr   (clr_i),
      .i_push  (w_wr_en),
      .i_data  (w_wr_entry),
      .i_pop   (out_ready_i),
      .o_head  (w_head),
      .o_valid (out_valid_o),
      .o_drop  (w_drop),
      .o_count (fifo_count_o)
   );

   assign out_data_o = w_head.data;
   assign out_last_o = w_head.last;
   assign overflow_o = r_overflow;

endmodule

// File: tb/tb_sa_ws_psum_collector.sv
// Directed bench for the psum collector: alignment, framing, backpressure, overflow, reset/clear.
module tb_sa_ws_psum_collector;

   localparam int SA_COL = 3;
   localparam int PW     = 19;
   localparam int VL     = 8;
   localparam int FD     = 4;
   localparam int CW     = $clog2(FD) + 1;

   logic                      clk = 1'b0;
   logic                      nrst;
   logic                      clr_i;
   logic                      psum_valid_i;
   logic [SA_COL-1:0][PW-1:0] psum_i;
   logic                      out_valid_o;
   logic                      out_ready_i;
   logic [SA_COL-1:0][PW-1:0] out_data_o;
   logic                      out_last_o;
   logic                      overflow_o;
   logic [CW-1:0]             fifo_count_o;

   int n_vec = 0;
   int n_bad = 0;
   bit sched_vld [128];
   int sched_id  [128];
   int base;
   int cyc;

   always #5 clk = ~clk;

   sa_ws_psum_collector #(
      .SA_COL        (SA_COL),
      .PSUM_WIDTH    (PW),
      .VECTOR_LENGTH (VL),
      .FIFO_DEPTH    (FD)
   ) dut (
      .clk          (clk),
      .nrst         (nrst),
      .clr_i        (clr_i),
      .psum_valid_i (psum_valid_i),
      .psum_i       (psum_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .out_last_o   (out_last_o),
      .overflow_o   (overflow_o),
      .fifo_count_o (fifo_count_o)
   );

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
      end else begin
         $display("ok   %s cyc=%0d value=%0h", tag, cyc, obs);
      end
   endtask

   // Expected aligned vector k: column c carries base + 10k + c.
   function automatic logic [63:0] exp_vec(input int k);
      logic [63:0] v;
      v = '0;
      for (int c = 0; c < SA_COL; c++) v[c*PW +: PW] = PW'(base + 10*k + c);
      return v;
   endfunction

   // Drive cycle t: column c shows the vector whose column 0 was at cycle t-c, else noise.
   task automatic set_inputs(input int t);
      psum_valid_i = (t >= 0 && t < 128) ? sched_vld[t] : 1'b0;
      for (int c = 0; c < SA_COL; c++) begin
         int s;
         s = t - c;
         if (s >= 0 && s < 128 && sched_vld[s]) psum_i[c] = PW'(base + 10*sched_id[s] + c);
         else                                    psum_i[c] = PW'($urandom);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
      cyc++;
      set_inputs(cyc);
   endtask

   task automatic new_test(input int b);
      for (int i = 0; i < 128; i++) begin
         sched_vld[i] = 1'b0;
         sched_id[i]  = 0;
      end
      base         = b;
      out_ready_i  = 1'b0;
      psum_valid_i = 1'b0;
      clr_i        = 1'b1;
      @(posedge clk);
      #1;
      clr_i = 1'b0;
      cyc   = 0;
   endtask

   task automatic sched(input int first_cyc, input int n);
      for (int i = 0; i < n; i++) begin
         sched_vld[first_cyc + i] = 1'b1;
         sched_id[first_cyc + i]  = i;
      end
      set_inputs(0);
   endtask

   task automatic chk_head(input string tag, input int k, input bit last);
      chk_eq({tag, "_valid"}, 64'(out_valid_o), 64'(1));
      chk_eq({tag, "_data"},  64'(out_data_o),  exp_vec(k));
      chk_eq({tag, "_last"},  64'(out_last_o),  64'(last));
   endtask

   task automatic chk_idle(input string tag);
      chk_eq({tag, "_valid"}, 64'(out_valid_o),  64'(0));
      chk_eq({tag, "_data"},  64'(out_data_o),   64'(0));
      chk_eq({tag, "_last"},  64'(out_last_o),   64'(0));
      chk_eq({tag, "_count"}, 64'(fifo_count_o), 64'(0));
   endtask

   initial begin
      nrst         = 1'b0;
      clr_i        = 1'b0;
      psum_valid_i = 1'b0;
      psum_i       = '0;
      out_ready_i  = 1'b0;
      base         = 0;
      cyc          = 0;

      // Reset state
      #12;
      chk_idle("rst");
      chk_eq("rst_ovf", 64'(overflow_o), 64'(0));
      @(posedge clk);
      #1;
      nrst = 1'b1;

      // Aligned delivery of a single vector {3,2,1}
      new_test(1);
      out_ready_i = 1'b1;
      sched(0, 1);
      for (int t = 0; t <= 6; t++) begin
         if (t == 3) chk_head("align", 0, 1'b0);
         else        chk_eq("align_valid", 64'(out_valid_o), 64'(0));
         adv();
      end

      // Frame marking: 9 back-to-back vectors, last only on vector 7
      new_test(0);
      out_ready_i = 1'b1;
      sched(0, 9);
      for (int t = 0; t <= 13; t++) begin
         if (t >= 3 && t <= 11) chk_head("frame", t - 3, (t - 3) == 7);
         else                   chk_eq("frame_valid", 64'(out_valid_o), 64'(0));
         adv();
      end

      // Backpressure: fill to 4, hold head, then drain in order
      new_test(100);
      sched(0, 4);
      while (cyc < 6) adv();
      chk_eq("bp_count", 64'(fifo_count_o), 64'(4));
      chk_head("bp_hold", 0, 1'b0);
      chk_eq("bp_ovf", 64'(overflow_o), 64'(0));
      adv();
      chk_head("bp_stable", 0, 1'b0);
      out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_eq("bp_drain_count", 64'(fifo_count_o), 64'(4 - i));
         chk_head("bp_drain", i, 1'b0);
         adv();
      end
      chk_eq("bp_empty_count", 64'(fifo_count_o), 64'(0));
      chk_eq("bp_empty_valid", 64'(out_valid_o), 64'(0));

      // Overflow: 5th vector dropped, flag sticky until clear
      new_test(200);
      sched(0, 5);
      while (cyc < 6) adv();
      chk_eq("ovf_before", 64'(overflow_o), 64'(0));
      adv();
      chk_eq("ovf_set", 64'(overflow_o), 64'(1));
      chk_eq("ovf_count", 64'(fifo_count_o), 64'(4));
      out_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk_head("ovf_drain", i, 1'b0);
         adv();
      end
      chk_eq("ovf_empty_count", 64'(fifo_count_o), 64'(0));
      chk_eq("ovf_sticky", 64'(overflow_o), 64'(1));
      clr_i = 1'b1;
      adv();
      clr_i = 1'b0;
      chk_eq("ovf_cleared", 64'(overflow_o), 64'(0));

      // Full with simultaneous pop: write accepted, no drop
      new_test(300);
      sched(0, 5);
      while (cyc < 6) adv();
      chk_eq("fp_full", 64'(fifo_count_o), 64'(4));
      out_ready_i = 1'b1;
      adv();
      out_ready_i = 1'b0;
      chk_eq("fp_count", 64'(fifo_count_o), 64'(4));
      chk_eq("fp_ovf", 64'(overflow_o), 64'(0));
      chk_head("fp_head", 1, 1'b0);
      out_ready_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk_head("fp_drain", i, 1'b0);
         adv();
      end
      chk_eq("fp_ovf_end", 64'(overflow_o), 64'(0));

      // Asynchronous reset mid-stream
      new_test(400);
      sched(0, 3);
      while (cyc < 4) adv();
      chk_eq("ar_pre_count", 64'(fifo_count_o), 64'(2));
      #3;
      nrst = 1'b0;
      #1;
      chk_idle("ar_now");
      chk_eq("ar_ovf", 64'(overflow_o), 64'(0));
      @(posedge clk);
      #1;
      nrst = 1'b1;
      out_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         adv();
         chk_eq("ar_no_stale", 64'(out_valid_o), 64'(0));
      end

      // Synchronous clear mid-stream
      new_test(500);
      sched(0, 3);
      while (cyc < 4) adv();
      chk_eq("sc_pre_count", 64'(fifo_count_o), 64'(2));
      clr_i = 1'b1;
      adv();
      clr_i = 1'b0;
      chk_idle("sc_edge");
      out_ready_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         adv();
         chk_eq("sc_no_stale", 64'(out_valid_o), 64'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
